// File: rtl/ext_sram_pkg.sv
// rtl/ext_sram_pkg.sv - shared types and constants for the external SRAM controller
package ext_sram_pkg;

   localparam int XLEN           = 32;
   localparam int XLEN_BYTES     = XLEN / 8;
   localparam int SRAM_DATA_BITS = 16;

   localparam logic HALF_LO = 1'b0;
   localparam logic HALF_HI = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      ACK
   } state_e;

endpackage

// File: rtl/ext_sram_controller.sv
// rtl/ext_sram_controller.sv - 32-bit word port to 16-bit async SRAM bridge with wait states
// Each word access becomes up to two half-word strobes; writes skip halves with no byte enables.
module ext_sram_controller
   import ext_sram_pkg::*;
#(
   parameter int WAIT_CYCLES    = 2,
   parameter int MEM_ADDR_BITS  = 16,
   parameter int SRAM_ADDR_BITS = MEM_ADDR_BITS + 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      sync_reset,
   input  logic [MEM_ADDR_BITS-1:0]  mem_addr,
   input  logic                      mem_read_en,
   input  logic                      mem_write_en,
   input  logic [XLEN_BYTES-1:0]     mem_byte_enable,
   input  logic [XLEN-1:0]           mem_write_data,
   output logic                      mem_ack,
   output logic [XLEN-1:0]           mem_read_data,
   output logic [SRAM_ADDR_BITS-1:0] sram_addr,
   input  logic [SRAM_DATA_BITS-1:0] sram_dq_in,
   output logic [SRAM_DATA_BITS-1:0] sram_dq_out,
   output logic                      sram_dq_oe,
   output logic                      sram_ce_n,
   output logic                      sram_oe_n,
   output logic                      sram_we_n,
   output logic                      sram_lb_n,
   output logic                      sram_ub_n
);

   localparam int              CW       = $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LOAD = CW'(WAIT_CYCLES);

   state_e                     state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [MEM_ADDR_BITS-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]            wdata_q, wdata_d;
   logic [XLEN_BYTES-1:0]      be_q, be_d;
   logic                       write_q, write_d;
   logic [SRAM_DATA_BITS-1:0]  lo_cap_q, lo_cap_d;
   logic [XLEN-1:0]            rdata_q, rdata_d;

   logic                       last_cycle;
   logic                       active;
   logic                       half;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      write_d    = write_q;
      lo_cap_d   = lo_cap_q;
      rdata_d    = rdata_q;
      last_cycle = (cnt_q == '0);

      case (state_q)
         IDLE: begin
            if (mem_write_en) begin
               addr_d  = mem_addr;
               wdata_d = mem_write_data;
               be_d    = mem_byte_enable;
               write_d = 1'b1;
               cnt_d   = CNT_LOAD;
               if (|mem_byte_enable[1:0])      state_d = LO;
               else if (|mem_byte_enable[3:2]) state_d = HI;
               else                            state_d = ACK;
            end else if (mem_read_en) begin
               addr_d  = mem_addr;
               write_d = 1'b0;
               cnt_d   = CNT_LOAD;
               state_d = LO;
            end
         end
         LO: begin
            if (last_cycle) begin
               if (!write_q) lo_cap_d = sram_dq_in;
               cnt_d   = CNT_LOAD;
               state_d = (!write_q || (|be_q[3:2])) ? HI : ACK;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HI: begin
            if (last_cycle) begin
               // Read data is published only when the whole word is in, so it holds between acks.
               if (!write_q) rdata_d = {sram_dq_in, lo_cap_q};
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         write_q  <= 1'b0;
         lo_cap_q <= '0;
         rdata_q  <= '0;
      end else if (sync_reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         write_q  <= 1'b0;
         lo_cap_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         write_q  <= write_d;
         lo_cap_q <= lo_cap_d;
         rdata_q  <= rdata_d;
      end
   end

   // Strobes decode straight from state so an async reset drops them without waiting for a clock.
   always_comb begin
      active        = (state_q == LO) || (state_q == HI);
      half          = (state_q == HI) ? HALF_HI : HALF_LO;
      mem_ack       = (state_q == ACK);
      mem_read_data = rdata_q;
      sram_addr     = SRAM_ADDR_BITS'({addr_q, half});
      sram_ce_n     = !active;
      sram_oe_n     = !(active && !write_q);
      sram_we_n     = !(active && write_q && !last_cycle);
      sram_dq_oe    = active && write_q;
      sram_dq_out   = '0;
      sram_lb_n     = 1'b1;
      sram_ub_n     = 1'b1;
      if (sram_dq_oe) begin
         sram_dq_out = half ? wdata_q[XLEN-1:SRAM_DATA_BITS] : wdata_q[SRAM_DATA_BITS-1:0];
      end
      if (active && !write_q) begin
         sram_lb_n = 1'b0;
         sram_ub_n = 1'b0;
      end else if (active) begin
         sram_lb_n = half ? !be_q[2] : !be_q[0];
         sram_ub_n = half ? !be_q[3] : !be_q[1];
      end
   end

   assert property (@(posedge clk) disable iff (!reset_n || sync_reset)
      !(mem_read_en && mem_write_en));
   assert property (@(posedge clk) disable iff (!reset_n || sync_reset)
      (mem_read_en || mem_write_en) |-> (state_q == IDLE));

endmodule

// File: tb/tb_ext_sram_controller.sv
// tb/tb_ext_sram_controller.sv - randomized bench for ext_sram_controller at WAIT_CYCLES 2, 1 and 5
// A word-level reference memory and latency formulas predict every ack and read word.
module tb_ext_sram_controller;

   localparam int NI  = 3;
   localparam int MAB = 8;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic        sync_reset = 1'b0;
   logic [2:0]  rd_s       = '0;
   logic [2:0]  wr_s       = '0;
   logic [7:0]  addr_s  [NI];
   logic [3:0]  be_s    [NI];
   logic [31:0] wdata_s [NI];

   logic [2:0]  ack_w, ce_w, oe_w, we_w, lb_w, ub_w, dqoe_w;
   logic [31:0] rdata_w [NI];
   logic [8:0]  saddr_w [NI];
   logic [15:0] dqo_w   [NI];
   logic [15:0] dqi_w   [NI];

   logic [15:0] smem    [NI][512];
   logic [31:0] ref_mem [NI][256];

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;

   int          req_cyc     [NI];
   int          exp_ack_cyc [NI];
   logic        exp_wr      [NI];
   logic [3:0]  exp_be      [NI];
   logic [31:0] exp_wd      [NI];
   logic [31:0] exp_rd      [NI];
   logic [31:0] held        [NI];
   logic [8:0]  prev_saddr  [NI];
   logic        prev_we     [NI];
   logic        sync_prev;

   int          st_lat, st_we_lo, st_we_hi, st_act_lo, st_act_hi, st_bad;
   logic [15:0] st_dq;
   logic        st_lb, st_ub;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      ext_sram_controller #(
         .WAIT_CYCLES   ((g == 0) ? 2 : ((g == 1) ? 1 : 5)),
         .MEM_ADDR_BITS (MAB)
      ) u_dut (
         .clk             (clk),
         .reset_n         (reset_n),
         .sync_reset      (sync_reset),
         .mem_addr        (addr_s[g]),
         .mem_read_en     (rd_s[g]),
         .mem_write_en    (wr_s[g]),
         .mem_byte_enable (be_s[g]),
         .mem_write_data  (wdata_s[g]),
         .mem_ack         (ack_w[g]),
         .mem_read_data   (rdata_w[g]),
         .sram_addr       (saddr_w[g]),
         .sram_dq_in      (dqi_w[g]),
         .sram_dq_out     (dqo_w[g]),
         .sram_dq_oe      (dqoe_w[g]),
         .sram_ce_n       (ce_w[g]),
         .sram_oe_n       (oe_w[g]),
         .sram_we_n       (we_w[g]),
         .sram_lb_n       (lb_w[g]),
         .sram_ub_n       (ub_w[g])
      );
   end

   always @(posedge clk)
      for (int i = 0; i < NI; i++)
         if (!ce_w[i] && !we_w[i]) begin
            if (!lb_w[i]) smem[i][saddr_w[i]][7:0]  <= dqo_w[i][7:0];
            if (!ub_w[i]) smem[i][saddr_w[i]][15:8] <= dqo_w[i][15:8];
         end

   always_comb
      for (int i = 0; i < NI; i++)
         dqi_w[i] = (!ce_w[i] && !oe_w[i]) ? smem[i][saddr_w[i]] : 16'h0000;

   function automatic int wv(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
   endfunction

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0h expected %0h at cycle %0d", nm, i, act, exp, cyc);
      end
   endtask

   task automatic compare();
      logic ack_exp, busy, half;
      for (int i = 0; i < NI; i++) begin
         if (!reset_n || sync_prev) held[i] = '0;
         ack_exp = (cyc == exp_ack_cyc[i]);
         chk("mem_ack", i, 32'(ack_w[i]), 32'(ack_exp));
         if (ack_exp && !exp_wr[i]) held[i] = exp_rd[i];
         chk("mem_read_data", i, rdata_w[i], held[i]);
         busy = (cyc > req_cyc[i]) && (cyc < exp_ack_cyc[i]);
         half = saddr_w[i][0];
         if (!busy) begin
            chk("strobes_idle", i, 32'({ce_w[i], oe_w[i], we_w[i], lb_w[i], ub_w[i], dqoe_w[i]}), 32'h3E);
         end else if (!exp_wr[i]) begin
            chk("read_strobes", i, 32'({ce_w[i], oe_w[i], we_w[i], lb_w[i], ub_w[i], dqoe_w[i]}), 32'h08);
         end else begin
            chk("write_strobes", i, 32'({ce_w[i], oe_w[i], dqoe_w[i]}), 32'h3);
            chk("write_dq_out", i, 32'(dqo_w[i]), 32'(half ? exp_wd[i][31:16] : exp_wd[i][15:0]));
            chk("write_lanes", i, 32'({lb_w[i], ub_w[i]}),
                32'(half ? {~exp_be[i][2], ~exp_be[i][3]} : {~exp_be[i][0], ~exp_be[i][1]}));
            chk("write_half_enabled", i, 32'(half ? |exp_be[i][3:2] : |exp_be[i][1:0]), 32'h1);
         end
         if (reset_n && saddr_w[i] != prev_saddr[i])
            chk("addr_change_we_high", i, 32'(prev_we[i]), 32'h1);
         prev_saddr[i] = saddr_w[i];
         prev_we[i]    = we_w[i];
      end
      sync_prev = sync_reset;
   endtask

   task automatic do_req(input int i, input logic wr, input logic [7:0] a, input logic [3:0] be,
                         input logic [31:0] d);
      int w, nh;
      @(posedge clk); #1;
      w          = wv(i);
      addr_s[i]  = a;
      be_s[i]    = be;
      wdata_s[i] = d;
      if (wr) wr_s[i] = 1'b1; else rd_s[i] = 1'b1;
      req_cyc[i] = cyc;
      exp_wr[i]  = wr;
      exp_be[i]  = be;
      exp_wd[i]  = d;
      if (wr) begin
         nh = ((|be[1:0]) ? 1 : 0) + ((|be[3:2]) ? 1 : 0);
         for (int b = 0; b < 4; b++) if (be[b]) ref_mem[i][a][8*b +: 8] = d[8*b +: 8];
         exp_ack_cyc[i] = cyc + nh * (w + 1) + 1;
      end else begin
         exp_rd[i]      = ref_mem[i][a];
         exp_ack_cyc[i] = cyc + 2 * (w + 1) + 1;
      end
      @(posedge clk); #1;
      wr_s[i] = 1'b0;
      rd_s[i] = 1'b0;
      st_lat = -1; st_we_lo = 0; st_we_hi = 0; st_act_lo = 0; st_act_hi = 0; st_bad = 0;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (!ce_w[i]) begin
            if (saddr_w[i][8:1] != a) st_bad++;
            else if (saddr_w[i][0]) begin st_act_hi++; if (!we_w[i]) st_we_hi++; end
            else begin st_act_lo++; if (!we_w[i]) st_we_lo++; end
            st_dq = dqo_w[i];
            st_lb = lb_w[i];
            st_ub = ub_w[i];
         end
         if (ack_w[i]) begin
            st_lat = k;
            break;
         end
      end
      checks++;
      if (st_lat < 0) begin
         errors++;
         $display("FAIL ack_timeout[%0d] got no ack within 64 cycles, required one", i);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout got no finish, required one");
      $fatal(1);
   end

   initial begin
      logic [7:0]  ra;
      logic [3:0]  rbe;
      logic [31:0] rd;
      for (int i = 0; i < NI; i++) begin
         addr_s[i] = '0; be_s[i] = '0; wdata_s[i] = '0;
         req_cyc[i] = 0; exp_ack_cyc[i] = -1; exp_wr[i] = 1'b0;
         exp_be[i] = '0; exp_wd[i] = '0; exp_rd[i] = '0; held[i] = '0;
         prev_saddr[i] = '0; prev_we[i] = 1'b1;
         for (int a = 0; a < 256; a++) ref_mem[i][a] = '0;
      end
      sync_prev = 1'b0;
      fork
         forever begin
            @(negedge clk);
            compare();
         end
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ack", 0, 32'(ack_w[0]), 32'h0);
      chk("reset_rdata", 0, rdata_w[0], 32'h0);
      chk("reset_sram_addr", 0, 32'(saddr_w[0]), 32'h0);
      chk("reset_dq_out", 0, 32'(dqo_w[0]), 32'h0);
      chk("reset_strobes", 0, 32'({ce_w[0], oe_w[0], we_w[0], lb_w[0], ub_w[0], dqoe_w[0]}), 32'h3E);
      @(posedge clk); #1;
      reset_n = 1'b1;

      do_req(0, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
      chk("t1_latency", 0, st_lat, 7);
      chk("t1_we_low_lo", 0, st_we_lo, 2);
      chk("t1_we_low_hi", 0, st_we_hi, 2);
      chk("t1_active_lo", 0, st_act_lo, 3);
      chk("t1_active_hi", 0, st_act_hi, 3);
      chk("t1_bad_addr", 0, st_bad, 0);

      do_req(0, 1'b0, 8'h10, 4'h0, 32'h0);
      chk("t2_latency", 0, st_lat, 7);
      chk("t2_read_data", 0, rdata_w[0], 32'hDEADBEEF);

      do_req(0, 1'b1, 8'h10, 4'b0100, 32'h00AA0000);
      chk("t3_latency", 0, st_lat, 4);
      chk("t3_active_lo", 0, st_act_lo, 0);
      chk("t3_active_hi", 0, st_act_hi, 3);
      chk("t3_we_low_hi", 0, st_we_hi, 2);
      chk("t3_lanes", 0, 32'({st_ub, st_lb}), 32'h2);
      chk("t3_dq_out", 0, 32'(st_dq), 32'h00AA);

      do_req(0, 1'b1, 8'h20, 4'h0, 32'hFFFFFFFF);
      chk("t4_latency", 0, st_lat, 1);
      chk("t4_active", 0, st_act_lo + st_act_hi + st_bad, 0);
      do_req(0, 1'b0, 8'h10, 4'h0, 32'h0);
      chk("t4_b2b_latency", 0, st_lat, 7);
      chk("t4_b2b_data", 0, rdata_w[0], 32'hDEAABEEF);

      @(posedge clk); #1;
      addr_s[0] = 8'h30; be_s[0] = 4'hF; wdata_s[0] = 32'h12345678; wr_s[0] = 1'b1;
      req_cyc[0] = cyc; exp_wr[0] = 1'b1; exp_be[0] = 4'hF; exp_wd[0] = 32'h12345678;
      exp_ack_cyc[0] = cyc + 7;
      @(posedge clk); #1;
      wr_s[0] = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("t5_in_hi", 0, 32'({saddr_w[0][0], ce_w[0], we_w[0]}), 32'h4);
      reset_n = 1'b0;
      exp_ack_cyc[0] = -1;
      #1;
      chk("t5_strobes", 0, 32'({ce_w[0], oe_w[0], we_w[0], lb_w[0], ub_w[0], dqoe_w[0]}), 32'h3E);
      chk("t5_ack", 0, 32'(ack_w[0]), 32'h0);
      @(posedge clk);
      @(posedge clk); #1;
      reset_n = 1'b1;
      do_req(0, 1'b0, 8'h10, 4'h0, 32'h0);
      chk("t5_read_latency", 0, st_lat, 7);
      chk("t5_read_data", 0, rdata_w[0], 32'hDEAABEEF);

      @(posedge clk); #1;
      sync_reset = 1'b1;
      @(posedge clk); #1;
      sync_reset = 1'b0;
      @(negedge clk);
      chk("sync_reset_rdata", 0, rdata_w[0], 32'h0);

      for (int i = 0; i < NI; i++) begin
         for (int a = 0; a < 8; a++) do_req(i, 1'b1, 8'(a), 4'hF, $urandom);
         for (int n = 0; n < 40; n++) begin
            ra  = 8'($urandom_range(0, 7));
            rbe = 4'($urandom);
            rd  = $urandom;
            if ($urandom_range(0, 1) == 1) begin
               do_req(i, 1'b1, ra, rbe, rd);
            end else begin
               do_req(i, 1'b0, ra, 4'h0, 32'h0);
               chk("rand_read", i, rdata_w[i], ref_mem[i][ra]);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
         end
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
